// File: rtl/image_streamer.sv
// Frame buffer front end: loads one 28x28 byte frame, replays it row by row with row gaps, returns the classification.
// Latency: first pixel_o_valid two cycles after the last accepted byte; result visible the cycle after digit_i_valid.
// Backpressure: s_ready low outside LOAD; result_o held with result_valid until result_ready; pixel stream has none.
module image_streamer #(
  parameter int IMG_DIM = 28,
  parameter int ROW_GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  pixel_o,
  output logic        pixel_o_valid,
  input  logic [3:0]  digit_i,
  input  logic        digit_i_valid,
  output logic [3:0]  result_o,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [15:0] frame_cnt,
  output logic        busy,
  output logic        err_o
);

  localparam int FRAME = IMG_DIM * IMG_DIM;
  localparam int PTR_W = $clog2(FRAME);
  localparam int CNT_W = $clog2(IMG_DIM);
  localparam int GAP_W = (ROW_GAP > 0) ? $clog2(ROW_GAP + 1) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMG_DIM - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(ROW_GAP);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_STREAM,
    ST_WAIT,
    ST_RESULT
  } state_t;

  state_t             r_state;
  state_t             w_nxt;
  logic [7:0]         r_mem [FRAME];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_col;
  logic [CNT_W-1:0]   r_row;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_go;
  logic               r_s_ready;
  logic [7:0]         r_pixel;
  logic               r_pixel_vld;
  logic [3:0]         r_result;
  logic [15:0]        r_frame_cnt;
  logic               r_err;
  logic               w_accept;
  logic               w_rd_en;
  logic               w_res_hs;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_LOAD;
    else      r_state <= w_nxt;
  end

  // Next-state and per-cycle strobes; a read happens only after the entry cycle and outside row gaps.
  always_comb begin
    w_nxt    = r_state;
    w_accept = 1'b0;
    w_rd_en  = 1'b0;
    w_res_hs = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_accept = s_valid && r_s_ready;
        if (w_accept && (r_wr_ptr == PTR_LAST)) w_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        w_rd_en = r_go && (r_gap_cnt == '0);
        if (w_rd_en && (r_rd_ptr == PTR_LAST)) w_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (digit_i_valid) w_nxt = ST_RESULT;
      end
      ST_RESULT: begin
        w_res_hs = result_ready;
        if (w_res_hs) w_nxt = ST_LOAD;
      end
      default: w_nxt = ST_LOAD;
    endcase
  end

  // Frame buffer write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= s_data;
  end

  // Load pointer and host-side ready, registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_s_ready <= 1'b0;
    end else begin
      r_s_ready <= (w_nxt == ST_LOAD);
      if (w_accept) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
    end
  end

  // Stream sequencing: row/column walk, row gaps, pointer rewinds after the final read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr  <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_gap_cnt <= '0;
      r_go      <= 1'b0;
    end else if (r_state == ST_STREAM) begin
      r_go <= 1'b1;
      if (r_go && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end else if (w_rd_en) begin
        if (r_rd_ptr == PTR_LAST) begin
          r_rd_ptr <= '0;
          r_col    <= '0;
          r_row    <= '0;
          r_go     <= 1'b0;
        end else begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
          if (r_col == CNT_LAST) begin
            r_col <= '0;
            r_row <= r_row + CNT_W'(1);
            if (r_row != CNT_LAST) r_gap_cnt <= GAP_INIT;
          end else begin
            r_col <= r_col + CNT_W'(1);
          end
        end
      end
    end
  end

  // Registered buffer read drives the controller directly; data holds across gaps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pixel     <= '0;
      r_pixel_vld <= 1'b0;
    end else begin
      r_pixel_vld <= w_rd_en;
      if (w_rd_en) r_pixel <= r_mem[r_rd_ptr];
    end
  end

  // Result capture, frame counter and sticky protocol error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result    <= '0;
      r_frame_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if ((r_state == ST_WAIT) && digit_i_valid) r_result <= digit_i;
      if (w_res_hs) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (digit_i_valid && (r_state != ST_WAIT)) r_err <= 1'b1;
    end
  end

  assign s_ready       = r_s_ready;
  assign pixel_o       = r_pixel;
  assign pixel_o_valid = r_pixel_vld;
  assign result_o      = r_result;
  assign result_valid  = (r_state == ST_RESULT);
  assign frame_cnt     = r_frame_cnt;
  assign busy          = !((r_state == ST_LOAD) && (r_wr_ptr == '0));
  assign err_o         = r_err;

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer: default-gap instance plus a zero-gap instance.
// Outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Every wait is a bounded loop.
module tb_image_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] s_data = '0;
  logic [3:0] digit_i = '0;

  // default-gap instance
  logic       s_valid = 1'b0, dv = 1'b0, rr = 1'b0;
  logic       sr, pv, rv, bz, er;
  logic [7:0] pd;
  logic [3:0] ro;
  logic [15:0] fc;

  // zero-gap instance
  logic       s_valid0 = 1'b0, dv0 = 1'b0, rr0 = 1'b0;
  logic       sr0, pv0, rv0, bz0, er0;
  logic [7:0] pd0;
  logic [3:0] ro0;
  logic [15:0] fc0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  image_streamer #(.IMG_DIM(28), .ROW_GAP(2)) u_dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(sr),
    .pixel_o(pd), .pixel_o_valid(pv), .digit_i(digit_i), .digit_i_valid(dv),
    .result_o(ro), .result_valid(rv), .result_ready(rr), .frame_cnt(fc),
    .busy(bz), .err_o(er)
  );

  image_streamer #(.IMG_DIM(28), .ROW_GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid0), .s_ready(sr0),
    .pixel_o(pd0), .pixel_o_valid(pv0), .digit_i(digit_i), .digit_i_valid(dv0),
    .result_o(ro0), .result_valid(rv0), .result_ready(rr0), .frame_cnt(fc0),
    .busy(bz0), .err_o(er0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] pat(input int mode, input int k);
    return (mode == 0) ? 8'(k) : 8'(k * 7 + 3);
  endfunction

  task automatic load_frame(input bit sel, input bit rnd, input int nbytes, input int mode);
    int k = 0;
    int guard = 0;
    bit vb, acc;
    while (k < nbytes && guard < 4000) begin
      vb = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data = pat(mode, k);
      if (sel) s_valid0 = vb; else s_valid = vb;
      acc = vb && (sel ? sr0 : sr);
      tick();
      if (acc) k++;
      guard++;
    end
    s_valid  = 1'b0;
    s_valid0 = 1'b0;
    check("load_accepts", k, nbytes);
  endtask

  task automatic capture(input bit sel, input int gap, input int mode, input int inj);
    int first = -1, last = -1, nv = 0, bad_pix = 0, bad_frm = 0, rdy_hi = 0;
    int period = 28 + gap;
    int span = 784 + 27 * gap;
    bit vld, exp_v;
    logic [7:0] dat;
    for (int c = 1; c <= span + 6; c++) begin
      if (c == inj) dv = 1'b1;
      tick();
      dv = 1'b0;
      vld = sel ? pv0 : pv;
      dat = sel ? pd0 : pd;
      if (sel ? sr0 : sr) rdy_hi++;
      if (vld) begin
        if (first < 0) first = c;
        last = c;
        if (dat !== pat(mode, nv)) bad_pix++;
        nv++;
      end
      if (first >= 0) begin
        exp_v = ((c - first) < span) && (((c - first) % period) < 28);
        if (vld !== exp_v) bad_frm++;
      end
    end
    check("stream_first_valid", first, 2);
    check("stream_valid_count", nv, 784);
    check("stream_length", last - first + 1, span);
    check("stream_pixel_errs", bad_pix, 0);
    check("stream_framing_errs", bad_frm, 0);
    check("s_ready_during_stream", rdy_hi, 0);
  endtask

  task automatic get_result(input bit sel, input logic [3:0] d, input int hold, input int exp_cnt);
    int bad = 0;
    digit_i = d;
    if (sel) dv0 = 1'b1; else dv = 1'b1;
    tick();
    dv  = 1'b0;
    dv0 = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (!((sel ? rv0 : rv) === 1'b1 && (sel ? ro0 : ro) === d)) bad++;
      tick();
    end
    check("result_hold", bad, 0);
    if (sel) rr0 = 1'b1; else rr = 1'b1;
    tick();
    rr  = 1'b0;
    rr0 = 1'b0;
    check("result_valid_after_hs", sel ? rv0 : rv, 0);
    check("s_ready_after_hs", sel ? sr0 : sr, 1);
    check("frame_cnt", sel ? fc0 : fc, exp_cnt);
    check("busy_after_hs", sel ? bz0 : bz, 0);
  endtask

  initial begin
    // reset state
    #2 rst = 1'b0;
    tick();
    tick();
    check("rst_s_ready", sr, 0);
    check("rst_pixel_o", pd, 0);
    check("rst_pixel_valid", pv, 0);
    check("rst_result_o", ro, 0);
    check("rst_result_valid", rv, 0);
    check("rst_frame_cnt", fc, 0);
    check("rst_busy", bz, 0);
    check("rst_err", er, 0);
    rst = 1'b1;
    tick();
    check("s_ready_after_release", sr, 1);

    // frame 1: contiguous k mod 256
    load_frame(1'b0, 1'b0, 784, 0);
    check("s_ready_after_last", sr, 0);
    check("busy_after_load", bz, 1);
    capture(1'b0, 2, 0, -1);
    check("err_clean", er, 0);
    get_result(1'b0, 4'd7, 10, 1);

    // frame 2: random s_valid, host keeps valid high during stream, spurious digit mid-stream
    load_frame(1'b0, 1'b1, 784, 0);
    s_valid = 1'b1;
    capture(1'b0, 2, 0, 100);
    s_valid = 1'b0;
    check("err_set_by_stream_pulse", er, 1);
    check("no_result_from_stream_pulse", rv, 0);
    get_result(1'b0, 4'd3, 2, 2);
    check("err_sticky", er, 1);

    // mid-frame reset after 400 bytes
    load_frame(1'b0, 1'b0, 400, 1);
    check("busy_partial", bz, 1);
    rst = 1'b0;
    #1;
    check("mrst_s_ready", sr, 0);
    check("mrst_pixel_o", pd, 0);
    check("mrst_result_o", ro, 0);
    check("mrst_frame_cnt", fc, 0);
    check("mrst_busy", bz, 0);
    check("mrst_err", er, 0);
    tick();
    rst = 1'b1;
    tick();
    check("s_ready_after_mrst", sr, 1);
    load_frame(1'b0, 1'b0, 784, 1);
    capture(1'b0, 2, 1, -1);
    get_result(1'b0, 4'd5, 3, 1);

    // zero-gap instance: three back-to-back frames
    for (int f = 0; f < 3; f++) begin
      load_frame(1'b1, 1'b0, 784, f % 2);
      capture(1'b1, 0, f % 2, -1);
      get_result(1'b1, 4'(f + 1), 1, f + 1);
    end
    check("gap0_err", er0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/image_streamer.md
# image_streamer

Upstream front end of the CNN. Accepts a 28x28 8-bit grayscale image as a byte stream from the host side, buffers the complete frame, then replays it row by row into the CNN controller's `pixel_i`/`pixel_i_valid` input with idle gaps between rows for line-buffer turnaround. It then waits for the controller's `digit_o`/`digit_o_valid` classification and returns it to the host through a valid/ready result port, one frame at a time.

## Interface
- `IMG_DIM`, 28: image width and height in pixels; frame = IMG_DIM*IMG_DIM = 784 bytes.
- `ROW_GAP`, 2: idle cycles inserted after each streamed row except the last; 0 is legal.
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `s_data` in 8: host pixel byte, raster order, row 0 column 0 first.
- `s_valid` in 1: host byte valid.
- `s_ready` out 1: block accepts a byte; transfer on `s_valid && s_ready`.
- `pixel_o` out 8: pixel to the controller's `pixel_i`.
- `pixel_o_valid` out 1: to the controller's `pixel_i_valid`; no backpressure.
- `digit_i` in 4: classification from the controller's `digit_o`.
- `digit_i_valid` in 1: from the controller's `digit_o_valid`, single-cycle pulse.
- `result_o` out 4: classified digit for the host.
- `result_valid` out 1: result available.
- `result_ready` in 1: host accepts; transfer on `result_valid && result_ready`.
- `frame_cnt` out 16: completed result handshakes, wraps 65535 -> 0.
- `busy` out 1: high in every state except LOAD with zero bytes stored.
- `err_o` out 1: sticky; set by `digit_i_valid` outside WAIT; cleared only by reset.

## Operation
- Storage: 784 x 8 frame buffer, synchronous-read; write pointer `wr_ptr` and read pointer `rd_ptr` of 10 bits each; row counter and column counter of 5 bits each; gap counter sized for ROW_GAP.
- LOAD: `s_ready`=1. Each handshake writes `mem[wr_ptr]`, increments `wr_ptr`. The handshake with `wr_ptr`=783 moves to STREAM; `wr_ptr` returns to 0.
- STREAM: `s_ready`=0. Reads `rd_ptr` 0..783 in order: IMG_DIM consecutive read cycles per row, then ROW_GAP cycles with no read. No gap after row 27. After the read of pixel 783 the state moves to WAIT.
- WAIT: `s_ready`=0, `pixel_o_valid`=0. `digit_i_valid` captures `digit_i` into `result_o` and moves to RESULT.
- RESULT: `result_valid`=1, `result_o` held stable until the handshake. The handshake increments `frame_cnt` and moves to LOAD.
- `digit_i_valid` in LOAD, STREAM, or RESULT is ignored for data, sets `err_o`, and causes no state change.
- `s_valid` outside LOAD is not accepted; the host holds its data.
- Reset, including mid-frame: all outputs 0, state LOAD, all pointers and counters 0, partial frame discarded. Buffer contents are not cleared.

## Timing
- Reset values: `s_ready`=0 while `rst` is low, then 1 from the first edge after release. `pixel_o`=0, `pixel_o_valid`=0, `result_o`=0, `result_valid`=0, `frame_cnt`=0, `busy`=0, `err_o`=0.
- A byte accepted at edge N is readable from edge N+1.
- Last-byte handshake at edge E: `s_ready` is low after E. The first `pixel_o_valid` is high in the cycle after edge E+2, because of one cycle of state entry plus one cycle of registered RAM read.
- `pixel_o_valid` pattern: 28 high cycles, then ROW_GAP low cycles, repeated 28 times with no trailing gap. Stream length is 784 + 27*ROW_GAP cycles (838 at the default). `pixel_o` is registered and equals `mem[k]` in the k-th valid cycle.
- `pixel_o` holds its last value while `pixel_o_valid`=0.
- `digit_i_valid` sampled at edge D in WAIT: `result_valid`=1 and `result_o` updated after D.
- `digit_i_valid` arriving at the same edge as the final STREAM read is outside WAIT: it sets `err_o` and the frame stays in WAIT.
- Result handshake at edge H: `result_valid`=0 and `s_ready`=1 after H, so the next frame's first byte can be accepted at H+1. `frame_cnt` is updated after H.

## Test plan
- Reset, then load bytes `k mod 256` for k = 0..783 with `s_valid` held high. Required: exactly 784 accepts; `pixel_o` sequence is 0..255, 0..255, 0..255, 0..15 in valid cycles; `pixel_o_valid` has 28-on/2-off framing; total stream 838 cycles; first valid 2 cycles after the last accept.
- Toggle `s_valid` randomly (50%) during LOAD. Required: stored and streamed data identical to the contiguous case; no byte is accepted outside LOAD.
- In WAIT, pulse `digit_i_valid` with `digit_i`=7 while `result_ready`=0 for 10 cycles, then raise it. Required: `result_o`=7 stable with `result_valid`=1 for 10 cycles; `frame_cnt` goes 0 -> 1; `s_ready`=1 the next cycle.
- Pulse `digit_i_valid` during STREAM. Required: `err_o`=1 and stays 1; streaming continues unchanged; a later WAIT pulse with `digit_i`=3 yields `result_o`=3.
- Assert `rst` low after 400 loaded bytes, release, then load a full new frame. Required: all outputs at reset values; the new frame streams correctly with no stale pointer offset.
- Run 3 back-to-back frames with ROW_GAP=0. Required: 784 contiguous valid cycles per frame; `frame_cnt` reaches 3.
